// File: rtl/cpu_decode_stage.sv
// Decode stage: instruction field decode, 32-entry register file, EX/MEM/WB operand
// forwarding, load-use stall and a handshaked ID/EX register. Optional macro: DECODE_WB_BYPASS_EN.
module cpu_decode_stage #(
  parameter int WIDTH      = 32,
  parameter bit IMM_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr_in,
  output logic             id_ready,
  input  logic [4:0]       ex_wnum,
  input  logic             ex_write,
  input  logic             ex_is_load,
  input  logic [WIDTH-1:0] ex_result,
  input  logic [4:0]       mem_wnum,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [4:0]       wb_wnum,
  input  logic             wb_write,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic [5:0]       out_opcode,
  output logic [5:0]       out_funct,
  output logic [WIDTH-1:0] out_rdata1,
  output logic [WIDTH-1:0] out_rdata2,
  output logic [WIDTH-1:0] out_imm,
  output logic [WIDTH-1:0] out_addr,
  output logic [4:0]       out_wnum
);

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign opcode = instr_in[31:26];
  assign rs     = instr_in[25:21];
  assign rt     = instr_in[20:16];
  assign rd     = instr_in[15:11];
  assign imm16  = instr_in[15:0];
  assign funct  = instr_in[5:0];

  // Register file: entry 0 is never written and is masked on read.
  logic [WIDTH-1:0] rf_reg [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (wb_write && (wb_wnum != 5'd0)) begin
      rf_reg[wb_wnum] <= wb_data;
    end
  end

  // Per-operand forwarding and hazard detection; operand 0 is rs, operand 1 is rt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [4:0]       src;
      logic             ex_hit;
      logic             mem_hit;
      logic             wb_hit;
      logic             load_hit;
      logic [WIDTH-1:0] fwd_val;

      assign src      = (gi == 0) ? rs : rt;
      assign ex_hit   = ex_write && (ex_wnum == src) && (src != 5'd0);
      assign mem_hit  = mem_write && (mem_wnum == src) && (src != 5'd0);
      assign wb_hit   = wb_write && (wb_wnum == src) && (src != 5'd0);
      assign load_hit = ex_hit && ex_is_load;

      always_comb begin
        fwd_val = '0;
        if (ex_hit) begin
          fwd_val = ex_result;
        end else if (mem_hit) begin
          fwd_val = mem_result;
`ifdef DECODE_WB_BYPASS_EN
        end else if (wb_hit) begin
          fwd_val = wb_data;
`endif
        end else if (src != 5'd0) begin
          fwd_val = rf_reg[src];
        end
      end
    end
  endgenerate

  logic stall;
  logic advance;

`ifdef DECODE_WB_BYPASS_EN
  assign stall = in_valid && (g_opnd[0].load_hit || g_opnd[1].load_hit);
`else
  // Without the bypass a register being written this cycle is not yet visible, so wait one cycle.
  assign stall = in_valid && (g_opnd[0].load_hit || g_opnd[1].load_hit ||
                              g_opnd[0].wb_hit || g_opnd[1].wb_hit);
`endif

  assign advance  = ex_ready || !out_valid;
  assign id_ready = flush || (advance && !stall);

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] addr_ext;
  logic [4:0]       wnum_sel;

  generate
    if (IMM_SIGNED) begin : g_imm_sext
      assign imm_ext = {{(WIDTH-16){imm16[15]}}, imm16};
    end else begin : g_imm_zext
      assign imm_ext = {{(WIDTH-16){1'b0}}, imm16};
    end
  endgenerate

  assign addr_ext = {{(WIDTH-26){1'b0}}, instr_in[25:0]};
  assign wnum_sel = (opcode == 6'd0) ? rd : rt;

  // ID/EX pipeline register
  logic             valid_reg;
  logic [5:0]       opcode_reg;
  logic [5:0]       funct_reg;
  logic [WIDTH-1:0] rdata1_reg;
  logic [WIDTH-1:0] rdata2_reg;
  logic [WIDTH-1:0] imm_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [4:0]       wnum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      opcode_reg <= '0;
      funct_reg  <= '0;
      rdata1_reg <= '0;
      rdata2_reg <= '0;
      imm_reg    <= '0;
      addr_reg   <= '0;
      wnum_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (advance && stall) begin
      valid_reg <= 1'b0;
    end else if (advance) begin
      valid_reg  <= in_valid;
      opcode_reg <= opcode;
      funct_reg  <= funct;
      rdata1_reg <= g_opnd[0].fwd_val;
      rdata2_reg <= g_opnd[1].fwd_val;
      imm_reg    <= imm_ext;
      addr_reg   <= addr_ext;
      wnum_reg   <= wnum_sel;
    end
  end

  assign out_valid  = valid_reg;
  assign out_opcode = opcode_reg;
  assign out_funct  = funct_reg;
  assign out_rdata1 = rdata1_reg;
  assign out_rdata2 = rdata2_reg;
  assign out_imm    = imm_reg;
  assign out_addr   = addr_reg;
  assign out_wnum   = wnum_reg;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Randomized plus directed bench for cpu_decode_stage against a cycle-level reference model;
// a second instance with sign-extended immediates shares all inputs.
module tb_cpu_decode_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  instr_in;
  logic [4:0]   ex_wnum, mem_wnum, wb_wnum;
  logic         ex_write, ex_is_load, mem_write, wb_write;
  logic [W-1:0] ex_result, mem_result, wb_data;
  logic         flush, ex_ready;

  logic         id_ready, out_valid;
  logic [5:0]   out_opcode, out_funct;
  logic [W-1:0] out_rdata1, out_rdata2, out_imm, out_addr;
  logic [4:0]   out_wnum;

  logic         s_id_ready, s_out_valid;
  logic [5:0]   s_out_opcode, s_out_funct;
  logic [W-1:0] s_out_rdata1, s_out_rdata2, s_out_imm, s_out_addr;
  logic [4:0]   s_out_wnum;

  always #5 clk = ~clk;

  cpu_decode_stage #(.WIDTH(W), .IMM_SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr_in(instr_in), .id_ready(id_ready),
    .ex_wnum(ex_wnum), .ex_write(ex_write), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_wnum(mem_wnum), .mem_write(mem_write), .mem_result(mem_result),
    .wb_wnum(wb_wnum), .wb_write(wb_write), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_rdata1(out_rdata1),
    .out_rdata2(out_rdata2), .out_imm(out_imm), .out_addr(out_addr), .out_wnum(out_wnum)
  );

  cpu_decode_stage #(.WIDTH(W), .IMM_SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr_in(instr_in), .id_ready(s_id_ready),
    .ex_wnum(ex_wnum), .ex_write(ex_write), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_wnum(mem_wnum), .mem_write(mem_write), .mem_result(mem_result),
    .wb_wnum(wb_wnum), .wb_write(wb_write), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .out_valid(s_out_valid),
    .out_opcode(s_out_opcode), .out_funct(s_out_funct), .out_rdata1(s_out_rdata1),
    .out_rdata2(s_out_rdata2), .out_imm(s_out_imm), .out_addr(s_out_addr), .out_wnum(s_out_wnum)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural register values and the ID/EX contents.
  logic [W-1:0] m_rf [32];
  bit           m_valid;
  logic [5:0]   m_opcode, m_funct;
  logic [W-1:0] m_rd1, m_rd2, m_imm, m_imm_s, m_addr;
  logic [4:0]   m_wnum;
  bit           last_ready;

  function automatic logic [W-1:0] model_operand(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (ex_write && ex_wnum == r) return ex_result;
    if (mem_write && mem_wnum == r) return mem_result;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_write && wb_wnum == r) return wb_data;
`endif
    return m_rf[r];
  endfunction

  function automatic logic [31:0] mk_instr(input int op, input int s, input int t, input int d,
                                           input int imm);
    logic [31:0] v;
    v = {op[5:0], s[4:0], t[4:0], imm[15:0]};
    if (op == 0) v[15:11] = d[4:0];
    return v;
  endfunction

  task automatic set_idle();
    in_valid = 0; instr_in = '0; flush = 0; ex_ready = 1;
    ex_write = 0; ex_is_load = 0; ex_wnum = '0; ex_result = '0;
    mem_write = 0; mem_wnum = '0; mem_result = '0;
    wb_write = 0; wb_wnum = '0; wb_data = '0;
  endtask

  // One clock: check id_ready, advance the model, then check the registered outputs.
  task automatic cycle();
    logic [4:0] s, t;
    bit stall, adv, exp_rdy;
    logic [31:0] ins;
    logic [W-1:0] n_rd1, n_rd2;
    #1;
    ins = instr_in;
    s = ins[25:21];
    t = ins[20:16];
    stall = in_valid && ex_write && ex_is_load && ex_wnum != 0 && (ex_wnum == s || ex_wnum == t);
`ifndef DECODE_WB_BYPASS_EN
    stall = stall || (in_valid && wb_write && wb_wnum != 0 && (wb_wnum == s || wb_wnum == t));
`endif
    adv = ex_ready || !m_valid;
    exp_rdy = flush || (adv && !stall);
    last_ready = id_ready;
    check_eq("id_ready", id_ready, exp_rdy);
    check_eq("s_id_ready", s_id_ready, exp_rdy);
    n_rd1 = model_operand(s);
    n_rd2 = model_operand(t);
    @(posedge clk);
    if (flush || (adv && stall)) begin
      m_valid = 0;
    end else if (adv) begin
      m_valid  = in_valid;
      m_opcode = ins[31:26];
      m_funct  = ins[5:0];
      m_rd1    = n_rd1;
      m_rd2    = n_rd2;
      m_imm    = W'(ins[15:0]);
      m_imm_s  = W'($signed(ins[15:0]));
      m_addr   = W'(ins[25:0]);
      m_wnum   = (ins[31:26] == 6'd0) ? ins[15:11] : ins[20:16];
    end
    if (wb_write && wb_wnum != 0) m_rf[wb_wnum] = wb_data;
    #1;
    check_eq("out_valid", out_valid, m_valid);
    check_eq("s_out_valid", s_out_valid, m_valid);
    if (m_valid) begin
      check_eq("out_opcode", out_opcode, m_opcode);
      check_eq("out_funct", out_funct, m_funct);
      check_eq("out_rdata1", out_rdata1, m_rd1);
      check_eq("out_rdata2", out_rdata2, m_rd2);
      check_eq("out_imm", out_imm, m_imm);
      check_eq("s_out_imm", s_out_imm, m_imm_s);
      check_eq("out_addr", out_addr, m_addr);
      check_eq("out_wnum", out_wnum, m_wnum);
    end
    @(negedge clk);
  endtask

  logic [W-1:0] held_imm;

  initial begin
    set_idle();
    rst = 1;
    // Writes during reset must be ignored.
    wb_write = 1; wb_wnum = 5'd4; wb_data = 32'h99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    set_idle();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 0; m_opcode = '0; m_funct = '0; m_rd1 = '0; m_rd2 = '0;
    m_imm = '0; m_imm_s = '0; m_addr = '0; m_wnum = '0;
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_opcode", out_opcode, 0);
    check_eq("rst_funct", out_funct, 0);
    check_eq("rst_rdata1", out_rdata1, 0);
    check_eq("rst_rdata2", out_rdata2, 0);
    check_eq("rst_imm", out_imm, 0);
    check_eq("rst_addr", out_addr, 0);
    check_eq("rst_wnum", out_wnum, 0);
    check_eq("rst_s_imm", s_out_imm, 0);
    $display("reset done");

    // WB write of r5 coinciding with a read of r5
    wb_write = 1; wb_wnum = 5'd5; wb_data = 32'hAA;
    in_valid = 1; instr_in = 32'h00A0_0000;
    cycle();
`ifdef DECODE_WB_BYPASS_EN
    check_eq("tp1_accept", last_ready, 1);
    wb_write = 0;
`else
    check_eq("tp1_stall", last_ready, 0);
    check_eq("tp1_bubble", out_valid, 0);
    wb_write = 0;
    cycle();
    check_eq("tp1_accept", last_ready, 1);
`endif
    check_eq("tp1_valid", out_valid, 1);
    check_eq("tp1_rdata1", out_rdata1, 32'hAA);
    $display("wb read-after-write: rdata1=0x%0h", out_rdata1);

    // EX beats MEM, then MEM alone
    ex_write = 1; ex_wnum = 5'd5; ex_result = 32'h11;
    mem_write = 1; mem_wnum = 5'd5; mem_result = 32'h22;
    instr_in = mk_instr(0, 5, 5, 7, 16'h0020);
    cycle();
    check_eq("tp2_ex_rd1", out_rdata1, 32'h11);
    check_eq("tp2_ex_rd2", out_rdata2, 32'h11);
    ex_write = 0;
    cycle();
    check_eq("tp2_mem_rd1", out_rdata1, 32'h22);
    check_eq("tp2_mem_rd2", out_rdata2, 32'h22);
    check_eq("tp2_wnum", out_wnum, 5'd7);
    mem_write = 0;
    $display("forwarding: ex then mem priority checked");

    // Load-use stall
    ex_write = 1; ex_is_load = 1; ex_wnum = 5'd3; ex_result = 32'h33;
    instr_in = mk_instr(6'h23, 1, 3, 0, 16'h0004);
    cycle();
    check_eq("tp3_stall", last_ready, 0);
    check_eq("tp3_bubble", out_valid, 0);
    ex_is_load = 0; ex_write = 0;
    cycle();
    check_eq("tp3_accept", last_ready, 1);
    check_eq("tp3_valid", out_valid, 1);
    check_eq("tp3_wnum", out_wnum, 5'd3);
    $display("load-use: one bubble then accept");

    // EX back-pressure for three cycles
    held_imm = out_imm;
    ex_ready = 0;
    instr_in = mk_instr(6'h08, 2, 6, 0, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("tp4_hold_ready", last_ready, 0);
      check_eq("tp4_hold_imm", out_imm, held_imm);
    end
    ex_ready = 1;
    cycle();
    check_eq("tp4_accept", last_ready, 1);
    check_eq("tp4_new_imm", out_imm, 32'h1234);
    $display("back-pressure: held 3 cycles then loaded");

    // Flush while holding under back-pressure
    ex_ready = 0; flush = 1;
    instr_in = mk_instr(0, 1, 2, 3, 16'h0821);
    cycle();
    check_eq("tp5_ready", last_ready, 1);
    check_eq("tp5_valid", out_valid, 0);
    flush = 0; ex_ready = 1; in_valid = 0;
    $display("flush: output invalidated");

    // r0 writes and forwarding attempts are ignored; immediate extension
    wb_write = 1; wb_wnum = 5'd0; wb_data = 32'hFFFF_FFFF;
    cycle();
    wb_write = 0;
    ex_write = 1; ex_wnum = 5'd0; ex_result = 32'h55;
    in_valid = 1; instr_in = mk_instr(6'h0C, 0, 0, 0, 16'h8000);
    cycle();
    check_eq("tp6_r0_rd1", out_rdata1, 0);
    check_eq("tp6_imm_zext", out_imm, 32'h0000_8000);
    check_eq("tp6_imm_sext", s_out_imm, 32'hFFFF_8000);
    set_idle();
    $display("r0 and immediate extension checked");

    // Randomized traffic on a small register range to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      if (!in_valid || last_ready) begin
        logic [31:0] r;
        r = $urandom;
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        r[15:11] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) r[31:26] = 6'd0;
        instr_in = r;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      ex_write   = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_wnum    = 5'($urandom_range(0, 7));
      ex_result  = $urandom;
      mem_write  = $urandom_range(0, 1);
      mem_wnum   = 5'($urandom_range(0, 7));
      mem_result = $urandom;
      wb_write   = $urandom_range(0, 1);
      wb_wnum    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      flush      = ($urandom_range(0, 15) == 0);
      ex_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end
    $display("random phase: 2000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
